// File: rtl/kpn_channel_arbiter.sv
// Sequencing controller for one bounded KPN channel: round-robin arbitration of two
// producers onto the fifo_module write port, one blocking consumer, local occupancy count.
module kpn_channel_arbiter #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5,
  parameter int COUNT_BITS    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_1,
  input  logic                   req_2,
  input  logic [BITS_NUMBER-1:0] entry_1,
  input  logic [BITS_NUMBER-1:0] entry_2,
  output logic                   grant_1,
  output logic                   grant_2,
  input  logic                   rd_req,
  output logic [BITS_NUMBER-1:0] output_1,
  output logic                   data_valid,
  output logic                   fifo_wr,
  output logic                   fifo_rd,
  output logic [BITS_NUMBER-1:0] fifo_entry,
  input  logic [BITS_NUMBER-1:0] fifo_output,
  output logic [COUNT_BITS-1:0]  count,
  output logic                   full,
  output logic                   empty
);

  typedef enum logic {WR_IDLE, WR_PULSE} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_PULSE, RD_WAIT, RD_DONE} rd_state_e;

  localparam logic [COUNT_BITS-1:0] FULL_LEVEL = COUNT_BITS'(FIFO_ELEMENTS);
  localparam logic [COUNT_BITS-1:0] ONE        = COUNT_BITS'(1);

  wr_state_e             wr_state_q;
  rd_state_e             rd_state_q;
  logic                  grant_1_q, grant_2_q, fifo_wr_q, fifo_rd_q, data_valid_q;
  logic                  last_grant_2_q;
  logic [BITS_NUMBER-1:0] fifo_entry_q, output_1_q;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  full_q, empty_q;
  logic                  wr_commit, sel_2, rd_commit;

  // Commit decisions use the pre-edge count, so a write can never land in a full channel.
  always_comb begin
    wr_commit = (wr_state_q == WR_IDLE) && !full_q && (req_1 || req_2);
    sel_2     = req_2 && (!req_1 || !last_grant_2_q);
    rd_commit = (rd_state_q == RD_IDLE) && rd_req && !empty_q;
    if (wr_commit && !rd_commit) begin
      count_d = count_q + ONE;
    end else if (rd_commit && !wr_commit) begin
      count_d = count_q - ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == FULL_LEVEL);
      empty_q <= (count_d == '0);
    end
  end

  // Write side: last_grant_2_q=1 after reset gives producer 1 first priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_state_q     <= WR_IDLE;
      fifo_wr_q      <= 1'b0;
      grant_1_q      <= 1'b0;
      grant_2_q      <= 1'b0;
      fifo_entry_q   <= '0;
      last_grant_2_q <= 1'b1;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (wr_commit) begin
            fifo_entry_q   <= sel_2 ? entry_2 : entry_1;
            fifo_wr_q      <= 1'b1;
            grant_1_q      <= !sel_2;
            grant_2_q      <= sel_2;
            last_grant_2_q <= sel_2;
            wr_state_q     <= WR_PULSE;
          end else begin
            fifo_wr_q <= 1'b0;
            grant_1_q <= 1'b0;
            grant_2_q <= 1'b0;
          end
        end
        WR_PULSE: begin
          fifo_wr_q  <= 1'b0;
          grant_1_q  <= 1'b0;
          grant_2_q  <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
        default: begin
          fifo_wr_q  <= 1'b0;
          grant_1_q  <= 1'b0;
          grant_2_q  <= 1'b0;
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Read side: the FIFO presents the token one cycle after its rd strobe; capture leaving RD_WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_state_q   <= RD_IDLE;
      fifo_rd_q    <= 1'b0;
      data_valid_q <= 1'b0;
      output_1_q   <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          data_valid_q <= 1'b0;
          if (rd_commit) begin
            fifo_rd_q  <= 1'b1;
            rd_state_q <= RD_PULSE;
          end else begin
            fifo_rd_q <= 1'b0;
          end
        end
        RD_PULSE: begin
          fifo_rd_q  <= 1'b0;
          rd_state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          output_1_q   <= fifo_output;
          data_valid_q <= 1'b1;
          rd_state_q   <= RD_DONE;
        end
        RD_DONE: begin
          data_valid_q <= 1'b0;
          rd_state_q   <= RD_IDLE;
        end
        default: begin
          fifo_rd_q    <= 1'b0;
          data_valid_q <= 1'b0;
          rd_state_q   <= RD_IDLE;
        end
      endcase
    end
  end

  assign grant_1    = grant_1_q;
  assign grant_2    = grant_2_q;
  assign fifo_wr    = fifo_wr_q;
  assign fifo_rd    = fifo_rd_q;
  assign fifo_entry = fifo_entry_q;
  assign output_1   = output_1_q;
  assign data_valid = data_valid_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_kpn_channel_arbiter.sv
// Bench for kpn_channel_arbiter: cycle table, directed corner sequences and randomized
// traffic, all checked against a token-timeline reference model and a fifo_module stand-in.
module tb_kpn_channel_arbiter;
  localparam int BN = 16;
  localparam int FE = 5;
  localparam int CB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_1 = 1'b1, req_2 = 1'b1, rd_req = 1'b1;
  logic [BN-1:0] entry_1 = '0, entry_2 = '0;
  logic          grant_1, grant_2, data_valid, fifo_wr, fifo_rd, full, empty;
  logic [BN-1:0] output_1, fifo_entry;
  logic [BN-1:0] fifo_output = '0;
  logic [CB-1:0] count;

  int checks = 0;
  int errors = 0;

  kpn_channel_arbiter #(.BITS_NUMBER(BN), .FIFO_ELEMENTS(FE), .COUNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .req_1(req_1), .req_2(req_2),
    .entry_1(entry_1), .entry_2(entry_2), .grant_1(grant_1), .grant_2(grant_2),
    .rd_req(rd_req), .output_1(output_1), .data_valid(data_valid),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_entry(fifo_entry),
    .fifo_output(fifo_output), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // fifo_module stand-in: registered read data, stores on wr, cleared by the shared reset.
  logic [BN-1:0] fmem [0:7];
  logic [2:0]    fwp = '0, frp = '0;
  always @(posedge clk) begin
    if (!reset) begin
      fwp <= '0;
      frp <= '0;
      fifo_output <= '0;
    end else begin
      if (fifo_rd) begin
        fifo_output <= fmem[frp];
        frp <= frp + 3'd1;
      end
      if (fifo_wr) begin
        fmem[fwp] <= fifo_entry;
        fwp <= fwp + 3'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: commits scheduled on an edge-number timeline, tokens kept in a queue.
  int n = 0, m_count = 0, m_last = 2, m_wr_next = 0, m_rd_next = 0, m_dv_at = -1;
  logic [BN-1:0] m_out = '0, m_entry = '0;
  logic [BN-1:0] tokq[$];
  bit e_g1, e_g2, e_wr, e_rd, e_dv;
  initial begin
    forever begin
      @(posedge clk);
      n++;
      e_g1 = 1'b0; e_g2 = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_dv = 1'b0;
      if (!reset) begin
        m_count = 0; m_last = 2; m_wr_next = n + 1; m_rd_next = n + 1;
        m_dv_at = -1; m_out = '0; m_entry = '0; tokq.delete();
      end else begin
        if (n >= m_wr_next && m_count < FE && (req_1 || req_2)) begin
          int sel;
          if (req_1 && req_2) sel = (m_last == 1) ? 2 : 1;
          else sel = req_1 ? 1 : 2;
          m_last = sel;
          m_entry = (sel == 1) ? entry_1 : entry_2;
          tokq.push_back(m_entry);
          e_wr = 1'b1; e_g1 = (sel == 1); e_g2 = (sel == 2);
          m_wr_next = n + 2;
        end
        if (n >= m_rd_next && m_count > 0 && rd_req) begin
          e_rd = 1'b1;
          m_rd_next = n + 4;
          m_dv_at = n + 2;
        end
        m_count = m_count + int'(e_wr) - int'(e_rd);
        if (m_dv_at == n) begin
          e_dv = 1'b1;
          m_out = tokq.pop_front();
        end
      end
      @(negedge clk);
      chk("m_grant_1", grant_1, e_g1);
      chk("m_grant_2", grant_2, e_g2);
      chk("m_fifo_wr", fifo_wr, e_wr);
      chk("m_fifo_rd", fifo_rd, e_rd);
      chk("m_data_valid", data_valid, e_dv);
      chk("m_output_1", output_1, m_out);
      chk("m_fifo_entry", fifo_entry, m_entry);
      chk("m_count", count, m_count);
      chk("m_count_bound", (count <= FE), 1);
      chk("m_full", full, (m_count == FE));
      chk("m_empty", empty, (m_count == 0));
    end
  end

  typedef struct {
    logic rst, r1, r2, rd;
    logic [BN-1:0] e1, e2;
    logic g1, g2, fwr, frd, dv;
    int cnt;
    logic [BN-1:0] out, ent;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, r1, input int e1, input logic r2, input int e2,
                     input logic rd, g1, g2, fwr, frd, dv, input int cnt, out, ent);
    vec_t v;
    v.rst = rst; v.r1 = r1; v.e1 = BN'(e1); v.r2 = r2; v.e2 = BN'(e2); v.rd = rd;
    v.g1 = g1; v.g2 = g2; v.fwr = fwr; v.frd = frd; v.dv = dv; v.cnt = cnt;
    v.out = BN'(out); v.ent = BN'(ent);
    tbl.push_back(v);
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_1 = 1'b0; req_2 = 1'b0; rd_req = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
  endtask

  task automatic write_tok(input int k, input int tok);
    int w;
    if (k == 1) begin req_1 = 1'b1; entry_1 = BN'(tok); end
    else begin req_2 = 1'b1; entry_2 = BN'(tok); end
    cycle();
    for (w = 0; w < 10 && !((k == 1) ? grant_1 : grant_2); w++) cycle();
    chk("write_grant", (k == 1) ? grant_1 : grant_2, 1);
    cycle();
    if (k == 1) req_1 = 1'b0; else req_2 = 1'b0;
  endtask

  task automatic read_tok(input int exp);
    int w;
    rd_req = 1'b1;
    cycle();
    for (w = 0; w < 12 && !data_valid; w++) cycle();
    chk("read_valid", data_valid, 1);
    chk("read_token", output_1, exp);
    cycle();
    rd_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bit d1, d2, drd;
    // rst r1 e1 r2 e2 rd | g1 g2 fwr frd dv cnt out ent
    add(0,1, 0,1, 0,1, 0,0,0,0,0, 0, 0, 0);
    add(0,1, 0,1, 0,1, 0,0,0,0,0, 0, 0, 0);
    add(1,1,10,0, 0,0, 1,0,1,0,0, 1, 0,10);
    add(1,1,10,0, 0,0, 0,0,0,0,0, 1, 0, 0);
    add(1,0, 0,0, 0,1, 0,0,0,1,0, 0, 0, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 0, 0, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,1, 0,10, 0);
    add(1,0, 0,0, 0,0, 0,0,0,0,0, 0,10, 0);
    add(0,0, 0,0, 0,0, 0,0,0,0,0, 0, 0, 0);
    add(1,1,20,1,30,0, 1,0,1,0,0, 1, 0,20);
    add(1,1,20,1,30,0, 0,0,0,0,0, 1, 0, 0);
    add(1,1,40,1,30,0, 0,1,1,0,0, 2, 0,30);
    add(1,1,40,1,30,0, 0,0,0,0,0, 2, 0, 0);
    add(1,1,40,1,50,0, 1,0,1,0,0, 3, 0,40);
    add(1,1,40,1,50,0, 0,0,0,0,0, 3, 0, 0);
    add(1,0, 0,1,50,0, 0,1,1,0,0, 4, 0,50);
    add(1,0, 0,1,50,0, 0,0,0,0,0, 4, 0, 0);
    add(1,0, 0,0, 0,1, 0,0,0,1,0, 3, 0, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 3, 0, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,1, 3,20, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 3,20, 0);
    add(1,0, 0,0, 0,1, 0,0,0,1,0, 2,20, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 2,20, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,1, 2,30, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 2,30, 0);
    add(1,0, 0,0, 0,1, 0,0,0,1,0, 1,30, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 1,30, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,1, 1,40, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 1,40, 0);
    add(1,0, 0,0, 0,1, 0,0,0,1,0, 0,40, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,0, 0,40, 0);
    add(1,0, 0,0, 0,1, 0,0,0,0,1, 0,50, 0);
    add(1,0, 0,0, 0,0, 0,0,0,0,0, 0,50, 0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; req_1 = tbl[i].r1; entry_1 = tbl[i].e1;
      req_2 = tbl[i].r2; entry_2 = tbl[i].e2; rd_req = tbl[i].rd;
      cycle();
      chk($sformatf("t%0d_grant_1", i), grant_1, tbl[i].g1);
      chk($sformatf("t%0d_grant_2", i), grant_2, tbl[i].g2);
      chk($sformatf("t%0d_fifo_wr", i), fifo_wr, tbl[i].fwr);
      chk($sformatf("t%0d_fifo_rd", i), fifo_rd, tbl[i].frd);
      chk($sformatf("t%0d_data_valid", i), data_valid, tbl[i].dv);
      chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("t%0d_empty", i), empty, (tbl[i].cnt == 0));
      chk($sformatf("t%0d_full", i), full, (tbl[i].cnt == FE));
      chk($sformatf("t%0d_output_1", i), output_1, tbl[i].out);
      if (tbl[i].fwr) chk($sformatf("t%0d_fifo_entry", i), fifo_entry, tbl[i].ent);
    end

    // Full channel blocks grants until a read frees a slot.
    do_reset();
    for (int i = 0; i < FE; i++) write_tok(1, 100 + i);
    chk("full_count", count, FE);
    chk("full_flag", full, 1);
    req_2 = 1'b1; entry_2 = 16'd200; seen = 0;
    for (int i = 0; i < 6; i++) begin cycle(); if (grant_2) seen = 1; end
    chk("full_no_grant", seen, 0);
    rd_req = 1'b1;
    cycle();
    for (int w = 0; w < 8 && !grant_2; w++) cycle();
    chk("full_grant_resumes", grant_2, 1);
    chk("full_count_back", count, FE);
    cycle();
    req_2 = 1'b0;
    for (int w = 0; w < 8 && !data_valid; w++) cycle();
    chk("full_read_token", output_1, 100);
    cycle();
    rd_req = 1'b0;

    // Empty channel holds the consumer off; then a same-edge write and read.
    do_reset();
    rd_req = 1'b1; seen = 0;
    for (int i = 0; i < 5; i++) begin cycle(); if (fifo_rd) seen = 1; end
    chk("empty_no_fifo_rd", seen, 0);
    chk("empty_count", count, 0);
    rd_req = 1'b0;
    cycle();
    write_tok(1, 61);
    write_tok(2, 62);
    chk("simul_pre_count", count, 2);
    req_1 = 1'b1; entry_1 = 16'd63; rd_req = 1'b1;
    cycle();
    chk("simul_fifo_wr", fifo_wr, 1);
    chk("simul_fifo_rd", fifo_rd, 1);
    chk("simul_count", count, 2);
    cycle();
    req_1 = 1'b0; rd_req = 1'b0;

    // Reset while the read waits for FIFO data.
    reset = 1'b0;
    cycle();
    chk("rst_mid_no_valid", data_valid, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_output", output_1, 0);
    reset = 1'b1; req_1 = 1'b1; entry_1 = 16'd77;
    cycle();
    chk("rst_mid_wr_idle", grant_1, 1);
    chk("rst_mid_no_late_valid", data_valid, 0);
    cycle();
    req_1 = 1'b0;
    read_tok(77);

    // Randomized traffic: slow consumer first to reach full, then a fast one.
    d1 = 0; d2 = 0; drd = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      reset = ($urandom_range(0, 599) != 0);
      if (d1) begin req_1 = ($urandom_range(0, 1) == 1); entry_1 = BN'($urandom); d1 = 0; end
      else if (!req_1 && $urandom_range(0, 2) == 0) begin req_1 = 1'b1; entry_1 = BN'($urandom); end
      if (d2) begin req_2 = ($urandom_range(0, 1) == 1); entry_2 = BN'($urandom); d2 = 0; end
      else if (!req_2 && $urandom_range(0, 2) == 0) begin req_2 = 1'b1; entry_2 = BN'($urandom); end
      if (drd) begin rd_req = 1'b0; drd = 0; end
      else if (!rd_req && $urandom_range(0, (i < 1500) ? 9 : 1) == 0) rd_req = 1'b1;
      if (grant_1) d1 = 1;
      if (grant_2) d2 = 1;
      if (data_valid) drd = 1;
    end
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
